// File: rtl/pp_pipeline_accel_fifo_to_axis_video_pkg.sv
// Shared definitions for the FIFO-to-AXIS video output stage:
// default widths and the frame controller state encoding.
package pp_pipeline_accel_fifo_to_axis_video_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int DIM_WIDTH_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/pp_pipeline_accel_fifo_to_axis_video_if.sv
// Handshake bundles for the output stage: the FWFT FIFO read port and the
// AXI4-Stream video port. "master" is the side that pulls/pushes data.
interface pp_pipeline_accel_fifo_rd_if
   import pp_pipeline_accel_fifo_to_axis_video_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  empty_n;
   logic [DATA_WIDTH-1:0] dout;
   logic                  read;

   modport master (input empty_n, input dout, output read);
   modport slave  (output empty_n, output dout, input read);
endinterface

interface pp_pipeline_accel_axis_if
   import pp_pipeline_accel_fifo_to_axis_video_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tuser;
   logic                  tlast;

   modport master (output tdata, output tvalid, input tready, output tuser, output tlast);
   modport slave  (input tdata, input tvalid, output tready, input tuser, input tlast);
endinterface

// File: rtl/pp_pipeline_accel_axis_skid2.sv
// Two-entry register buffer between the FIFO pop logic and the AXIS port.
// The output is taken straight from the head register; full is registered.
module pp_pipeline_accel_axis_skid2
   import pp_pipeline_accel_fifo_to_axis_video_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH_DEF + 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   output logic             full_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   input  logic             ready_i
);

   logic             headValid_q, headValid_d;
   logic             tailValid_q, tailValid_d;
   logic [WIDTH-1:0] headData_q, headData_d;
   logic [WIDTH-1:0] tailData_q, tailData_d;
   logic             pop, push;

   // The tail only ever holds a beat while the head is stalled, so a pop
   // with a full buffer promotes the tail and no push can coincide with it.
   always_comb begin
      pop         = headValid_q && ready_i;
      push        = push_i && !tailValid_q;
      headValid_d = headValid_q;
      tailValid_d = tailValid_q;
      headData_d  = headData_q;
      tailData_d  = tailData_q;
      if (pop && tailValid_q) begin
         headData_d  = tailData_q;
         tailValid_d = 1'b0;
      end else if (pop && push) begin
         headData_d = pushData_i;
      end else if (pop) begin
         headValid_d = 1'b0;
      end else if (push && !headValid_q) begin
         headValid_d = 1'b1;
         headData_d  = pushData_i;
      end else if (push) begin
         tailValid_d = 1'b1;
         tailData_d  = pushData_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         headValid_q <= 1'b0;
         tailValid_q <= 1'b0;
         headData_q  <= '0;
         tailData_q  <= '0;
      end else begin
         headValid_q <= headValid_d;
         tailValid_q <= tailValid_d;
         headData_q  <= headData_d;
         tailData_q  <= tailData_d;
      end
   end

   assign full_o  = tailValid_q;
   assign valid_o = headValid_q;
   assign data_o  = headData_q;

endmodule

// File: rtl/pp_pipeline_accel_fifo_to_axis_video.sv
// Drains one frame of rows*cols pixels from the last pipeline FIFO and emits
// it as AXI4-Stream video with TUSER on the first pixel and TLAST per line.
module pp_pipeline_accel_fifo_to_axis_video
   import pp_pipeline_accel_fifo_to_axis_video_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DIM_WIDTH  = DIM_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [DIM_WIDTH-1:0]     rows,
   input  logic [DIM_WIDTH-1:0]     cols,
   output logic                     busy,
   output logic                     done,
   pp_pipeline_accel_fifo_rd_if.master fifo,
   pp_pipeline_accel_axis_if.master    m_axis
);

   localparam int PW = DATA_WIDTH + 2;

   state_e               state_q;
   logic [DIM_WIDTH-1:0] rowsM1_q, colsM1_q, row_q, col_q;
   logic                 busy_q, done_q;
   logic                 bufFull, bufValid, popFifo, tagUser, tagLast;
   logic [PW-1:0]        pushPayload, headPayload;

   // Reset gates the pop so an aborted frame never consumes a FIFO word.
   assign popFifo     = (state_q == ST_RUN) && fifo.empty_n && !bufFull && !reset;
   assign fifo.read   = popFifo;
   assign tagUser     = (row_q == '0) && (col_q == '0);
   assign tagLast     = (col_q == colsM1_q);
   assign pushPayload = {tagUser, tagLast, fifo.dout};

   pp_pipeline_accel_axis_skid2 #(
      .WIDTH(PW)
   ) uSkid (
      .clk       (clk),
      .reset     (reset),
      .push_i    (popFifo),
      .pushData_i(pushPayload),
      .full_o    (bufFull),
      .valid_o   (bufValid),
      .data_o    (headPayload),
      .ready_i   (m_axis.tready)
   );

   assign m_axis.tvalid = bufValid;
   assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = headPayload;
   assign busy = busy_q;
   assign done = done_q;

   // End of frame comes from the row/col counters against the latched
   // limits minus one; zero-sized frames skip straight to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rowsM1_q <= '0;
         colsM1_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  rowsM1_q <= rows - DIM_WIDTH'(1);
                  colsM1_q <= cols - DIM_WIDTH'(1);
                  row_q    <= '0;
                  col_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ((rows == '0) || (cols == '0)) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (popFifo) begin
                  if (col_q == colsM1_q) begin
                     col_q <= '0;
                     row_q <= row_q + DIM_WIDTH'(1);
                     if (row_q == rowsM1_q) begin
                        state_q <= ST_DRAIN;
                     end
                  end else begin
                     col_q <= col_q + DIM_WIDTH'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (!bufValid) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_to_axis_video.sv
// Directed bench for the FIFO-to-AXIS video stage: a FWFT FIFO model feeds
// the DUT and a monitor records every accepted beat for later comparison.
module tb_pp_pipeline_accel_fifo_to_axis_video;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] rows, cols;
   logic        busy, done;

   pp_pipeline_accel_fifo_rd_if #(.DATA_WIDTH(32)) fifo ();
   pp_pipeline_accel_axis_if    #(.DATA_WIDTH(32)) axis ();

   pp_pipeline_accel_fifo_to_axis_video dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .rows  (rows),
      .cols  (cols),
      .busy  (busy),
      .done  (done),
      .fifo  (fifo),
      .m_axis(axis)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // FIFO model: written by the stimulus tasks, popped on the clock edge.
   logic [31:0] mem [0:255];
   logic [7:0]  wrPtr = 8'd0;
   logic [7:0]  rdPtr = 8'd0;
   assign fifo.empty_n = (wrPtr != rdPtr);
   assign fifo.dout    = mem[rdPtr];

   int          cycCnt = 0, popCnt = 0, readWhileEmpty = 0, beatCnt = 0;
   int          doneCnt = 0, stableErr = 0, validCyc = 0;
   logic [31:0] beatData [0:255];
   logic        beatUser [0:255];
   logic        beatLast [0:255];
   int          beatCyc  [0:255];
   logic        stallQ = 1'b0;
   logic [33:0] stallPayload = '0;

   // Records pops, accepted beats, done pulses and payload stability.
   always @(posedge clk) begin
      cycCnt <= cycCnt + 1;
      if (fifo.read && fifo.empty_n) begin
         rdPtr  <= rdPtr + 8'd1;
         popCnt <= popCnt + 1;
      end
      if (fifo.read && !fifo.empty_n) readWhileEmpty <= readWhileEmpty + 1;
      if (axis.tvalid) validCyc <= validCyc + 1;
      if (axis.tvalid && axis.tready) begin
         beatData[beatCnt] <= axis.tdata;
         beatUser[beatCnt] <= axis.tuser;
         beatLast[beatCnt] <= axis.tlast;
         beatCyc[beatCnt]  <= cycCnt;
         beatCnt           <= beatCnt + 1;
      end
      if (done) doneCnt <= doneCnt + 1;
      if (stallQ && (!axis.tvalid || {axis.tuser, axis.tlast, axis.tdata} !== stallPayload))
         stableErr <= stableErr + 1;
      stallQ       <= axis.tvalid && !axis.tready && !reset;
      stallPayload <= {axis.tuser, axis.tlast, axis.tdata};
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pushWord(input logic [31:0] w);
      mem[wrPtr] = w;
      wrPtr = wrPtr + 8'd1;
   endtask

   task automatic flushFifo();
      wrPtr = rdPtr;
   endtask

   task automatic startFrame(input logic [15:0] r, input logic [15:0] c);
      @(negedge clk);
      rows  = r;
      cols  = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (fifo.read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: got %b expected 0", fifo.read); end
      checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", axis.tvalid); end
      checks++; if ({axis.tuser, axis.tlast} !== 2'b00) begin errors++; $display("[TB] FAIL reset_tags: got %b%b expected 00", axis.tuser, axis.tlast); end
      checks++; if (axis.tdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", axis.tdata); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int pop0, beat0, done0, k;
      logic [33:0] exp;
      flushFifo();
      for (int i = 0; i < 6; i++) pushWord(32'h10 + i);
      axis.tready = 1'b1;
      pop0 = popCnt; beat0 = beatCnt; done0 = doneCnt;
      startFrame(16'd2, 16'd3);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_rise: got %b expected 1", busy); end
      checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL basic_tvalid_pre: got %b expected 0", axis.tvalid); end
      checks++; if (fifo.read !== 1'b1) begin errors++; $display("[TB] FAIL basic_first_read: got %b expected 1", fifo.read); end
      tick();
      k = 1;
      checks++; if ({axis.tvalid, axis.tuser, axis.tlast, axis.tdata} !== {3'b110, 32'h10}) begin
         errors++; $display("[TB] FAIL basic_first_beat: got v%b u%b l%b %h expected v1 u1 l0 00000010", axis.tvalid, axis.tuser, axis.tlast, axis.tdata);
      end
      while (k < 40 && done !== 1'b1) begin tick(); k++; end
      checks++; if (k !== 9) begin errors++; $display("[TB] FAIL basic_done_latency: got %0d expected 9", k); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_fall: got %b expected 0", busy); end
      checks++; if (beatCnt - beat0 !== 6) begin errors++; $display("[TB] FAIL basic_beats: got %0d expected 6", beatCnt - beat0); end
      checks++; if (popCnt - pop0 !== 6) begin errors++; $display("[TB] FAIL basic_pops: got %0d expected 6", popCnt - pop0); end
      for (int i = 0; i < 6; i++) begin
         exp = {(i == 0), (i % 3 == 2), 32'h10 + 32'(i)};
         checks++; if ({beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]} !== exp) begin
            errors++; $display("[TB] FAIL basic_beat%0d: got %h expected %h", i, {beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]}, exp);
         end
         checks++; if (beatCyc[beat0+i] - beatCyc[beat0] !== i) begin
            errors++; $display("[TB] FAIL basic_spacing%0d: got %0d expected %0d", i, beatCyc[beat0+i] - beatCyc[beat0], i);
         end
      end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width: got %b expected 0", done); end
      checks++; if (doneCnt - done0 !== 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", doneCnt - done0); end
   endtask

   task automatic test_backpressure();
      int pop0, beat0, done0, stab0, k;
      logic [33:0] exp;
      flushFifo();
      for (int i = 0; i < 6; i++) pushWord(32'h10 + i);
      axis.tready = 1'b1;
      pop0 = popCnt; beat0 = beatCnt; done0 = doneCnt; stab0 = stableErr;
      startFrame(16'd2, 16'd3);
      k = 0;
      while (k < 80 && done !== 1'b1) begin
         axis.tready = (k % 3 == 0);
         tick();
         k++;
      end
      axis.tready = 1'b1;
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done_seen: got %b expected 1", done); end
      checks++; if (beatCnt - beat0 !== 6) begin errors++; $display("[TB] FAIL bp_beats_before_done: got %0d expected 6", beatCnt - beat0); end
      checks++; if (popCnt - pop0 !== 6) begin errors++; $display("[TB] FAIL bp_pops: got %0d expected 6", popCnt - pop0); end
      checks++; if (stableErr - stab0 !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable stalls expected 0", stableErr - stab0); end
      for (int i = 0; i < 6; i++) begin
         exp = {(i == 0), (i % 3 == 2), 32'h10 + 32'(i)};
         checks++; if ({beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]} !== exp) begin
            errors++; $display("[TB] FAIL bp_beat%0d: got %h expected %h", i, {beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]}, exp);
         end
      end
      tick();
      checks++; if (doneCnt - done0 !== 1) begin errors++; $display("[TB] FAIL bp_done_count: got %0d expected 1", doneCnt - done0); end
   endtask

   task automatic test_slow_fifo();
      int pop0, beat0, rwe0, k, pushed;
      flushFifo();
      axis.tready = 1'b1;
      pop0 = popCnt; beat0 = beatCnt; rwe0 = readWhileEmpty;
      startFrame(16'd1, 16'd3);
      k = 0; pushed = 0;
      while (k < 60 && done !== 1'b1) begin
         if (k % 3 == 0 && pushed < 3) begin pushWord(32'h20 + pushed); pushed++; end
         tick();
         k++;
      end
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL slow_done_seen: got %b expected 1", done); end
      checks++; if (readWhileEmpty - rwe0 !== 0) begin errors++; $display("[TB] FAIL slow_read_while_empty: got %0d expected 0", readWhileEmpty - rwe0); end
      checks++; if (popCnt - pop0 !== 3) begin errors++; $display("[TB] FAIL slow_pops: got %0d expected 3", popCnt - pop0); end
      checks++; if (beatCnt - beat0 !== 3) begin errors++; $display("[TB] FAIL slow_beats: got %0d expected 3", beatCnt - beat0); end
      for (int i = 0; i < 3; i++) begin
         checks++; if ({beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]} !== {(i == 0), (i == 2), 32'h20 + 32'(i)}) begin
            errors++; $display("[TB] FAIL slow_beat%0d: got %h expected %h", i, {beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]}, {(i == 0), (i == 2), 32'h20 + 32'(i)});
         end
      end
      tick();
   endtask

   task automatic test_zero_dims();
      int pop0, val0;
      for (int pass = 0; pass < 2; pass++) begin
         flushFifo();
         pushWord(32'h99);
         pop0 = popCnt; val0 = validCyc;
         startFrame(pass == 0 ? 16'd0 : 16'd5, pass == 0 ? 16'd5 : 16'd0);
         checks++; if ({busy, done} !== 2'b10) begin errors++; $display("[TB] FAIL zero%0d_cycle1: got busy%b done%b expected busy1 done0", pass, busy, done); end
         tick();
         checks++; if ({busy, done} !== 2'b01) begin errors++; $display("[TB] FAIL zero%0d_cycle2: got busy%b done%b expected busy0 done1", pass, busy, done); end
         tick();
         checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero%0d_done_width: got %b expected 0", pass, done); end
         checks++; if (popCnt - pop0 !== 0) begin errors++; $display("[TB] FAIL zero%0d_pops: got %0d expected 0", pass, popCnt - pop0); end
         checks++; if (validCyc - val0 !== 0) begin errors++; $display("[TB] FAIL zero%0d_tvalid: got %0d valid cycles expected 0", pass, validCyc - val0); end
      end
      flushFifo();
   endtask

   task automatic test_over_read();
      int pop0, beat0, k;
      logic [7:0] remain;
      flushFifo();
      for (int i = 0; i < 10; i++) pushWord(32'h30 + i);
      axis.tready = 1'b1;
      for (int f = 0; f < 2; f++) begin
         pop0 = popCnt; beat0 = beatCnt;
         startFrame(16'd1, 16'd4);
         k = 0;
         while (k < 40 && done !== 1'b1) begin tick(); k++; end
         tick();
         remain = wrPtr - rdPtr;
         checks++; if (popCnt - pop0 !== 4) begin errors++; $display("[TB] FAIL over%0d_pops: got %0d expected 4", f, popCnt - pop0); end
         checks++; if (remain !== 8'(6 - 4 * f)) begin errors++; $display("[TB] FAIL over%0d_remain: got %0d expected %0d", f, remain, 6 - 4 * f); end
         for (int i = 0; i < 4; i++) begin
            checks++; if ({beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]} !== {(i == 0), (i == 3), 32'h30 + 32'(4 * f + i)}) begin
               errors++; $display("[TB] FAIL over%0d_beat%0d: got %h expected %h", f, i, {beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]}, {(i == 0), (i == 3), 32'h30 + 32'(4 * f + i)});
            end
         end
      end
      flushFifo();
   endtask

   task automatic test_reset_abort();
      int pop0, beat0, done0, k, popBefore;
      flushFifo();
      for (int i = 0; i < 6; i++) pushWord(32'h40 + i);
      axis.tready = 1'b1;
      beat0 = beatCnt; done0 = doneCnt;
      startFrame(16'd2, 16'd3);
      k = 0;
      while (k < 20 && beatCnt - beat0 < 2) begin tick(); k++; end
      checks++; if (beatCnt - beat0 !== 2) begin errors++; $display("[TB] FAIL abort_two_beats: got %0d expected 2", beatCnt - beat0); end
      checks++; if (axis.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL abort_valid_before: got %b expected 1", axis.tvalid); end
      popBefore = popCnt;
      reset = 1'b1;
      tick();
      checks++; if ({axis.tvalid, busy, done} !== 3'b000) begin errors++; $display("[TB] FAIL abort_cleared: got v%b busy%b done%b expected 000", axis.tvalid, busy, done); end
      checks++; if (popCnt !== popBefore) begin errors++; $display("[TB] FAIL abort_no_pop: got %0d expected %0d", popCnt, popBefore); end
      reset = 1'b0;
      repeat (4) tick();
      checks++; if (doneCnt - done0 !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", doneCnt - done0); end
      flushFifo();
      for (int i = 0; i < 6; i++) pushWord(32'h50 + i);
      pop0 = popCnt; beat0 = beatCnt; done0 = doneCnt;
      startFrame(16'd2, 16'd3);
      k = 0;
      while (k < 40 && done !== 1'b1) begin tick(); k++; end
      tick();
      checks++; if (popCnt - pop0 !== 6) begin errors++; $display("[TB] FAIL rerun_pops: got %0d expected 6", popCnt - pop0); end
      checks++; if (doneCnt - done0 !== 1) begin errors++; $display("[TB] FAIL rerun_done_count: got %0d expected 1", doneCnt - done0); end
      for (int i = 0; i < 6; i++) begin
         checks++; if ({beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]} !== {(i == 0), (i % 3 == 2), 32'h50 + 32'(i)}) begin
            errors++; $display("[TB] FAIL rerun_beat%0d: got %h expected %h", i, {beatUser[beat0+i], beatLast[beat0+i], beatData[beat0+i]}, {(i == 0), (i % 3 == 2), 32'h50 + 32'(i)});
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      rows        = '0;
      cols        = '0;
      axis.tready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_slow_fifo();
      test_zero_dims();
      test_over_read();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
